// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path types for the 5-stage RV32I core: opcodes, select encodings,
// the per-instruction control bundle carried down the pipeline, and branch-condition evaluation.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    alu_ctrl_e   alu_control;
    src_a_e      alu_src_a;
    logic        alu_src_b;
    logic [2:0]  funct3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = ctrl_bundle_t'('0);

  // Condition for a conditional branch, keyed on its funct3; reserved encodings never take.
  function automatic logic branch_cond(input logic [2:0] funct3, input logic zero,
                                       input logic lt, input logic ltu);
    logic c;
    case (funct3)
      3'b000:  c = zero;
      3'b001:  c = !zero;
      3'b100:  c = lt;
      3'b101:  c = !lt;
      3'b110:  c = ltu;
      3'b111:  c = !ltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from opcode/funct3/funct7b5; purely combinational.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_ctrl_e  alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    if (op_i == OP_BRANCH) begin
      alu_ctrl_o = ALU_SUB;
    end else if (op_i == OP_RTYPE || op_i == OP_ITYPE) begin
      case (funct3_i)
        // op[5] separates R-type from I-type: ADDI with instr[30] set is still ADD.
        3'b000:  alu_ctrl_o = (funct7b5_i && op_i[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl_o = ALU_SLL;
        3'b010:  alu_ctrl_o = ALU_SLT;
        3'b011:  alu_ctrl_o = ALU_SLTU;
        3'b100:  alu_ctrl_o = ALU_XOR;
        3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl_o = ALU_OR;
        default: alu_ctrl_o = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// RV32I control unit: decodes in ID, carries the control bundle through ID/EX, EX/MEM, MEM/WB.
// Optional macro PIPELINED_CONTROLLER_ILLEGAL_EN adds illegal_d_o / illegal_seen_o.
module pipelined_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter bit EXT_BRANCH = 1'b1,
  parameter bit EXT_UPPER  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [6:0]            op_d_i,
  input  logic [2:0]            funct3_d_i,
  input  logic                  funct7b5_d_i,
  input  logic                  flush_e_i,
  input  logic                  zero_e_i,
  input  logic                  lt_e_i,
  input  logic                  ltu_e_i,
  output logic [2:0]            imm_src_d_o,
  output logic [ALU_CTRL_W-1:0] alu_control_e_o,
  output logic [1:0]            alu_src_a_e_o,
  output logic                  alu_src_b_e_o,
  output logic                  pc_src_e_o,
  output logic                  jalr_e_o,
  output logic                  result_src_e0_o,
  output logic                  reg_write_m_o,
  output logic                  mem_write_m_o,
  output logic [2:0]            funct3_m_o,
  output logic                  reg_write_w_o,
  output logic [1:0]            result_src_w_o
`ifdef PIPELINED_CONTROLLER_ILLEGAL_EN
  ,
  output logic                  illegal_d_o,
  output logic                  illegal_seen_o
`endif
);

  alu_ctrl_e    w_alu_ctrl_d;
  ctrl_bundle_t w_ctrl_d;
  imm_src_e     w_imm_src_d;
  logic         w_legal_d;
  ctrl_bundle_t r_ex, r_mem, r_wb;
  logic         w_unused_wb;

  alu_decoder u_alu_decoder (
    .op_i       (op_d_i),
    .funct3_i   (funct3_d_i),
    .funct7b5_i (funct7b5_d_i),
    .alu_ctrl_o (w_alu_ctrl_d)
  );

  always_comb begin
    w_ctrl_d             = CTRL_BUBBLE;
    w_ctrl_d.alu_control = w_alu_ctrl_d;
    w_ctrl_d.funct3      = funct3_d_i;
    w_imm_src_d          = IMM_I;
    w_legal_d            = 1'b0;
    case (op_d_i)
      OP_LOAD: begin
        w_legal_d            = funct3_d_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.result_src  = RES_MEM;
        w_ctrl_d.alu_src_b   = 1'b1;
      end
      OP_STORE: begin
        w_legal_d            = funct3_d_i inside {3'b000, 3'b001, 3'b010};
        w_ctrl_d.mem_write   = 1'b1;
        w_ctrl_d.alu_src_b   = 1'b1;
        w_imm_src_d          = IMM_S;
      end
      OP_RTYPE: begin
        w_legal_d            = 1'b1;
        w_ctrl_d.reg_write   = 1'b1;
      end
      OP_ITYPE: begin
        w_legal_d            = 1'b1;
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.alu_src_b   = 1'b1;
      end
      OP_BRANCH: begin
        w_legal_d            = EXT_BRANCH ? !(funct3_d_i inside {3'b010, 3'b011})
                                          : (funct3_d_i == 3'b000);
        w_ctrl_d.branch      = 1'b1;
        w_imm_src_d          = IMM_B;
      end
      OP_JAL: begin
        w_legal_d            = 1'b1;
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.result_src  = RES_PC4;
        w_ctrl_d.jump        = 1'b1;
        w_imm_src_d          = IMM_J;
      end
      OP_JALR: begin
        w_legal_d            = EXT_UPPER && (funct3_d_i == 3'b000);
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.result_src  = RES_PC4;
        w_ctrl_d.jump        = 1'b1;
        w_ctrl_d.jalr        = 1'b1;
        w_ctrl_d.alu_src_b   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_legal_d            = EXT_UPPER;
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.alu_src_a   = (op_d_i == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
        w_ctrl_d.alu_src_b   = 1'b1;
        w_imm_src_d          = IMM_U;
      end
      default: w_legal_d = 1'b0;
    endcase
    // Anything unsupported leaves no trace downstream, including imm_src.
    if (!w_legal_d) begin
      w_ctrl_d    = CTRL_BUBBLE;
      w_imm_src_d = IMM_I;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ex  <= CTRL_BUBBLE;
      r_mem <= CTRL_BUBBLE;
      r_wb  <= CTRL_BUBBLE;
    end else begin
      r_ex  <= flush_e_i ? CTRL_BUBBLE : w_ctrl_d;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign imm_src_d_o     = w_imm_src_d;
  assign alu_control_e_o = ALU_CTRL_W'(r_ex.alu_control);
  assign alu_src_a_e_o   = r_ex.alu_src_a;
  assign alu_src_b_e_o   = r_ex.alu_src_b;
  assign pc_src_e_o      = r_ex.jump |
                           (r_ex.branch & branch_cond(r_ex.funct3, zero_e_i, lt_e_i, ltu_e_i));
  assign jalr_e_o        = r_ex.jalr;
  assign result_src_e0_o = r_ex.result_src[0];
  assign reg_write_m_o   = r_mem.reg_write;
  assign mem_write_m_o   = r_mem.mem_write;
  assign funct3_m_o      = r_mem.funct3;
  assign reg_write_w_o   = r_wb.reg_write;
  assign result_src_w_o  = r_wb.result_src;
  assign w_unused_wb     = ^r_wb;

`ifdef PIPELINED_CONTROLLER_ILLEGAL_EN
  logic r_illegal_seen;

  // A flushed illegal never reaches EX, so it is not recorded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_illegal_seen <= 1'b0;
    else if (!w_legal_d && !flush_e_i) r_illegal_seen <= 1'b1;
  end

  assign illegal_d_o    = !w_legal_d;
  assign illegal_seen_o = r_illegal_seen;
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed-vector bench for pipelined_controller: full build plus a minimal build (no branch/upper extensions).
module tb_pipelined_controller;
  import riscv_ctrl_pkg::*;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       b5, flush, zero, lt, ltu;

  logic [2:0] imm_src, f3_m, n_imm_src, n_f3_m;
  logic [3:0] alu_ctrl, n_alu_ctrl;
  logic [1:0] src_a, res_w, n_src_a, n_res_w;
  logic       src_b, pc_src, jalr, res_e0, rw_m, mw_m, rw_w;
  logic       n_src_b, n_pc_src, n_jalr, n_res_e0, n_rw_m, n_mw_m, n_rw_w;
`ifdef PIPELINED_CONTROLLER_ILLEGAL_EN
  logic       ill_d, ill_seen, n_ill_d, n_ill_seen;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_controller u_dut (
    .clk_i(clk), .rst_ni(rst_n), .op_d_i(op), .funct3_d_i(f3), .funct7b5_d_i(b5),
    .flush_e_i(flush), .zero_e_i(zero), .lt_e_i(lt), .ltu_e_i(ltu),
    .imm_src_d_o(imm_src), .alu_control_e_o(alu_ctrl), .alu_src_a_e_o(src_a),
    .alu_src_b_e_o(src_b), .pc_src_e_o(pc_src), .jalr_e_o(jalr), .result_src_e0_o(res_e0),
    .reg_write_m_o(rw_m), .mem_write_m_o(mw_m), .funct3_m_o(f3_m),
    .reg_write_w_o(rw_w), .result_src_w_o(res_w)
`ifdef PIPELINED_CONTROLLER_ILLEGAL_EN
    , .illegal_d_o(ill_d), .illegal_seen_o(ill_seen)
`endif
  );

  pipelined_controller #(.EXT_BRANCH(1'b0), .EXT_UPPER(1'b0)) u_dut_min (
    .clk_i(clk), .rst_ni(rst_n), .op_d_i(op), .funct3_d_i(f3), .funct7b5_d_i(b5),
    .flush_e_i(flush), .zero_e_i(zero), .lt_e_i(lt), .ltu_e_i(ltu),
    .imm_src_d_o(n_imm_src), .alu_control_e_o(n_alu_ctrl), .alu_src_a_e_o(n_src_a),
    .alu_src_b_e_o(n_src_b), .pc_src_e_o(n_pc_src), .jalr_e_o(n_jalr), .result_src_e0_o(n_res_e0),
    .reg_write_m_o(n_rw_m), .mem_write_m_o(n_mw_m), .funct3_m_o(n_f3_m),
    .reg_write_w_o(n_rw_w), .result_src_w_o(n_res_w)
`ifdef PIPELINED_CONTROLLER_ILLEGAL_EN
    , .illegal_d_o(n_ill_d), .illegal_seen_o(n_ill_seen)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic b);
    op = o; f3 = f; b5 = b; flush = 1'b0;
  endtask

  // Idle: unsupported opcode under flush, so nothing enters EX and no illegal is recorded.
  task automatic idle();
    op = 7'd0; f3 = 3'd0; b5 = 1'b0; flush = 1'b1;
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic b);
    drive(o, f, b);
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    idle();
    tick(); tick();
    check("reset_outs", {alu_ctrl, src_a, src_b, pc_src, jalr, res_e0, rw_m, mw_m, f3_m, rw_w, res_w}, 0);
    check("reset_outs_min", {n_alu_ctrl, n_src_a, n_src_b, n_pc_src, n_rw_m, n_mw_m, n_rw_w, n_res_w}, 0);
    rst_n = 1'b1;
    tick();
    check("post_reset_outs", {alu_ctrl, src_a, src_b, pc_src, jalr, res_e0, rw_m, mw_m, f3_m, rw_w, res_w}, 0);

    // add a0,a0,a1 (0x00B50533): WB write exactly 3 cycles after issue
    issue(OP_RTYPE, 3'b000, 1'b0);
    check("add_alu", alu_ctrl, 4'b0000);
    check("add_rw_w_ex", rw_w, 1'b0);
    tick();
    check("add_rw_m", rw_m, 1'b1);
    check("add_rw_w_mem", rw_w, 1'b0);
    tick();
    check("add_rw_w", rw_w, 1'b1);
    check("add_res_w", res_w, 2'b00);

    issue(OP_RTYPE, 3'b000, 1'b1);
    check("sub_alu", alu_ctrl, 4'b0001);
    issue(OP_ITYPE, 3'b000, 1'b1);
    check("addi_b5_alu", alu_ctrl, 4'b0000);
    check("addi_src_b", src_b, 1'b1);
    issue(OP_ITYPE, 3'b101, 1'b1);
    check("srai_alu", alu_ctrl, 4'b1001);
    issue(OP_RTYPE, 3'b101, 1'b0);
    check("srl_alu", alu_ctrl, 4'b1000);
    issue(OP_RTYPE, 3'b100, 1'b0);
    check("xor_alu", alu_ctrl, 4'b0100);
    issue(OP_RTYPE, 3'b011, 1'b0);
    check("sltu_alu", alu_ctrl, 4'b0110);

    issue(OP_BRANCH, 3'b001, 1'b0);
    zero = 1'b0; #1;
    check("bne_taken", pc_src, 1'b1);
    check("bne_alu", alu_ctrl, 4'b0001);
    check("bne_min_bubble", n_pc_src, 1'b0);
    zero = 1'b1; #1;
    check("bne_not_taken", pc_src, 1'b0);
    zero = 1'b0;
    issue(OP_BRANCH, 3'b111, 1'b0);
    ltu = 1'b1; #1;
    check("bgeu_not_taken", pc_src, 1'b0);
    ltu = 1'b0; #1;
    check("bgeu_taken", pc_src, 1'b1);
    issue(OP_BRANCH, 3'b100, 1'b0);
    lt = 1'b1; #1;
    check("blt_taken", pc_src, 1'b1);
    lt = 1'b0;
    issue(OP_BRANCH, 3'b000, 1'b0);
    check("beq_min_taken_cond", n_pc_src, 1'b0);
    zero = 1'b1; #1;
    check("beq_min", n_pc_src, 1'b1);
    zero = 1'b0;

    issue(OP_JALR, 3'b000, 1'b0);
    check("jalr_pc_src", pc_src, 1'b1);
    check("jalr_flag", jalr, 1'b1);
    check("jalr_min_bubble", n_jalr, 1'b0);
    tick(); tick();
    check("jalr_res_w", res_w, 2'b10);
    check("jalr_rw_w", rw_w, 1'b1);
    issue(OP_JAL, 3'b000, 1'b0);
    check("jal_pc_src_jalr", {pc_src, jalr}, 2'b10);

    // sw flushed in ID, lw right behind it
    drive(OP_STORE, 3'b010, 1'b0);
    flush = 1'b1;
    tick();
    check("sw_flush_ex", {src_b, alu_ctrl}, 0);
    issue(OP_LOAD, 3'b010, 1'b0);
    check("sw_flush_mw_m", mw_m, 1'b0);
    check("lw_res_e0", res_e0, 1'b1);
    tick();
    check("lw_f3_m", f3_m, 3'b010);
    check("lw_mw_m", mw_m, 1'b0);

    drive(OP_LUI, 3'b000, 1'b0); #1;
    check("lui_imm", imm_src, 3'b100);
    check("lui_imm_min", n_imm_src, 3'b000);
    tick(); idle();
    check("lui_src_a", src_a, 2'b10);
    tick(); tick();
    check("lui_rw_w", rw_w, 1'b1);
    check("lui_rw_w_min", n_rw_w, 1'b0);
    drive(OP_AUIPC, 3'b000, 1'b0); #1;
    check("auipc_imm", imm_src, 3'b100);
    tick(); idle();
    check("auipc_src_a", src_a, 2'b01);
    drive(OP_STORE, 3'b000, 1'b0); #1;
    check("sb_imm", imm_src, 3'b001);
    drive(OP_BRANCH, 3'b000, 1'b0); #1;
    check("beq_imm", imm_src, 3'b010);
    drive(OP_JAL, 3'b000, 1'b0); #1;
    check("jal_imm", imm_src, 3'b011);
    drive(OP_BRANCH, 3'b010, 1'b0); #1;
    check("bad_branch_imm", imm_src, 3'b000);
    idle();

    // async reset with a store sitting in MEM
    issue(OP_STORE, 3'b001, 1'b0);
    tick();
    check("sh_mw_m", mw_m, 1'b1);
    check("sh_f3_m", f3_m, 3'b001);
    rst_n = 1'b0; #1;
    check("rst_async_mw_m", mw_m, 1'b0);
    tick();
    rst_n = 1'b1;

`ifdef PIPELINED_CONTROLLER_ILLEGAL_EN
    drive(7'b0000000, 3'b000, 1'b0); #1;
    check("ill_d", ill_d, 1'b1);
    check("ill_seen_before", ill_seen, 1'b0);
    tick(); idle();
    check("ill_seen_set", ill_seen, 1'b1);
    tick(); tick();
    check("ill_seen_hold", ill_seen, 1'b1);
    drive(OP_BRANCH, 3'b001, 1'b0); #1;
    check("ill_min_bne", {ill_d, n_ill_d}, 2'b01);
    idle();
    rst_n = 1'b0; #1;
    check("ill_seen_rst", ill_seen, 1'b0);
    tick();
    rst_n = 1'b1;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Next-generation control unit for the 5-stage RV32I core.
- Decodes the instruction in ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB pipeline registers, with flush support.
- Resolves all six conditional branches, plus JAL/JALR, in EX from ALU flags.
- Adds shifts, XOR, SLTU, LUI and AUIPC.

Parameters:
- ALU_CTRL_W, 4: width of the ALU control code; must be ≥4.
- EXT_BRANCH, 1: 1 = BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 = BEQ only; other branch funct3 values decode as bubble.
- EXT_UPPER, 1: 1 = LUI/AUIPC/JALR decoded; 0 = those opcodes decode as bubble.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- op_d_i  in  7  instr[6:0] in ID
- funct3_d_i  in  3  instr[14:12] in ID
- funct7b5_d_i  in  1  instr[30] in ID
- flush_e_i  in  1  from hazard unit; next ID/EX contents become a bubble
- zero_e_i  in  1  ALU result == 0 (EX)
- lt_e_i  in  1  signed rs1<rs2 (EX)
- ltu_e_i  in  1  unsigned rs1<rs2 (EX)
- imm_src_d_o  out  3  immediate format in ID: I=000, S=001, B=010, J=011, U=100
- alu_control_e_o  out  ALU_CTRL_W  ALU operation in EX
- alu_src_a_e_o  out  2  operand A: 00 rs1, 01 PC, 10 zero
- alu_src_b_e_o  out  1  operand B: 0 rs2, 1 immediate
- pc_src_e_o  out  1  take branch/jump (EX)
- jalr_e_o  out  1  target = ALU result instead of PC+imm
- result_src_e0_o  out  1  bit 0 of result_src in EX; for load-use detection
- reg_write_m_o  out  1  MEM-stage write enable; for forwarding
- mem_write_m_o  out  1  store enable
- funct3_m_o  out  3  access size/sign for the LSU
- reg_write_w_o  out  1  WB write enable
- result_src_w_o  out  2  WB mux select: 00 ALU, 01 memory, 10 PC+4

Behaviour:
- Decode (ID) is combinational from the op, funct3 and funct7b5 inputs.
- Unknown or disabled opcodes decode to a bubble: every enable 0, all selects 0. Never X.
- Pipeline registers are ID→EX→MEM→WB, one register each. A control bit decoded in cycle n is visible in EX at n+1, MEM at n+2, WB at n+3.
- Reset (async assert, synchronous release): all registered stages become bubbles, all outputs 0.
- On flush_e_i at a clock edge, ID/EX loads a bubble. The EX/MEM and MEM/WB registers advance normally.
- Flush only affects the instruction entering EX. A flush and a taken branch in the same cycle is legal; the branch already in EX still moves to MEM.
- ALU decode, ALU_CTRL_W=4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- SUB is selected only when funct3=000, funct7b5=1 and op[5]=1 (R-type). ADDI always yields ADD.
- funct3=101 selects SRA when funct7b5=1 and SRL otherwise, for both R-type and I-type.
- Loads, stores, JALR and AUIPC use ADD. Branches use SUB.
- LUI: ALU ADD with operand A = zero. AUIPC: ALU ADD with operand A = PC.
- pc_src_e_o = jump_e | (branch_e & cond).
  - cond from funct3_e: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- jalr_e_o = 1 only for JALR in EX. JAL and JALR both write PC+4 (result_src 10).
- funct3 is piped unchanged to MEM.

Optional Feature:
- Macro PIPELINED_CONTROLLER_ILLEGAL_EN.
- When defined, adds two outputs:
  - illegal_d_o (1 bit): combinational, high when the ID opcode/funct3 pair is unsupported under the current parameters.
  - illegal_seen_o (1 bit): sticky, set on the first clock edge where illegal_d_o=1 and flush_e_i=0; cleared only by reset.
- When not defined, the ports are absent and illegal instructions silently decode to bubbles. Pipeline behaviour is identical in both builds.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams;
  - enums alu_ctrl_e, imm_src_e, result_src_e, src_a_e;
  - packed struct ctrl_bundle_t, holding reg_write, result_src, mem_write, jump, branch, jalr, alu_control, alu_src_a, alu_src_b and funct3;
  - the constant CTRL_BUBBLE, the all-zero bundle.
- One sub-module, alu_decoder, maps op, funct3 and funct7b5 to alu_ctrl_e.
- Pipeline registers live in the top as ctrl_bundle_t flops.

Test Plan:
- Reset held, then released: all outputs 0. Issue `add` (0x00B50533): reg_write_w_o=1 and result_src_w_o=00 exactly 3 cycles after issue.
- `sub` R-type (funct7b5=1, op 0110011) → alu_control_e_o=0001. `addi` with instr[30]=1 → 0000. `srai` (funct3 101, b5=1) → 1001.
- `bne` in EX with zero_e_i=0 → pc_src_e_o=1. `bgeu` with ltu_e_i=1 → pc_src_e_o=0. `jalr` → pc_src_e_o=1, jalr_e_o=1, result_src_w_o=10 in WB.
- `sw` in ID with flush_e_i=1 → next cycle EX bubble; mem_write_m_o stays 0 two cycles later. An `lw` issued the following cycle → result_src_e0_o=1, funct3_m_o=010.
- `lui` → imm_src_d_o=100, alu_src_a_e_o=10. With EXT_UPPER=0 the same instruction → reg_write_w_o=0. rst_ni pulsed low with a store in MEM → mem_write_m_o drops to 0 immediately.
- With the macro defined: opcode 0000000 → illegal_d_o=1; illegal_seen_o=1 after the edge and holds until reset.
